// File: rtl/tm_clause_defs.sv
// tm_clause_defs: shared clause-bank geometry and sequencer state encodings
package tm_clause_defs;
  localparam int CLAUSE_CHUNKS = 63;
  localparam int REG_WIDTH = 32;
  localparam int ADDR_W = 6;
  localparam int POS_W = 5;
  localparam int CNT_W = 11;
  typedef enum logic [2:0] {IDLE, REQ, LOAD, SCAN, DONE} state_t;
endpackage

// File: rtl/lsb_priority_encoder.sv
// lsb_priority_encoder: index of the lowest set bit of a word, plus any-bit flag
module lsb_priority_encoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) idx = in[i] ? IDX_W'(i) : idx;
  end
  assign any = |in;
endmodule

// File: rtl/clause_out_scanner.sv
// clause_out_scanner: walks the clause bank and streams (chunk, pos) of every set bit
module clause_out_scanner
  import tm_clause_defs::*;
(
  input  logic                 clk,
  input  logic                 rst_flag,
  input  logic                 start,
  output logic                 rd_mode,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [REG_WIDTH-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_chunk,
  output logic [POS_W-1:0]     out_pos,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     set_count
);
  state_t state, state_n;
  logic [ADDR_W-1:0] chunk_idx;
  logic [REG_WIDTH-1:0] work;
  logic any, last, fire;
  lsb_priority_encoder #(.WIDTH(REG_WIDTH), .IDX_W(POS_W)) u_enc (
    .in(work),
    .idx(out_pos),
    .any(any)
  );
  assign last = chunk_idx == ADDR_W'(CLAUSE_CHUNKS - 1);
  assign rd_mode = state == REQ;
  assign rd_addr = chunk_idx;
  assign out_valid = state == SCAN && any;
  assign out_chunk = chunk_idx;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign fire = out_valid && out_ready;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? REQ : IDLE;
      REQ: state_n = LOAD;
      LOAD: state_n = SCAN;
      SCAN: state_n = any ? SCAN : (last ? DONE : REQ);
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      state <= IDLE;
      chunk_idx <= '0;
      work <= '0;
      set_count <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        chunk_idx <= '0;
        set_count <= '0;
      end
      if (state == LOAD) work <= rd_data;
      if (state == SCAN && !any && !last) chunk_idx <= chunk_idx + ADDR_W'(1);
      if (fire) begin
        work <= work & (work - REG_WIDTH'(1));
        set_count <= set_count + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_clause_out_scanner.sv
// tb_clause_out_scanner: directed checks of the clause output scanner against a bank model
module tb_clause_out_scanner;
  logic clk = 1'b0;
  logic rst_flag, start, out_ready;
  logic rd_mode, out_valid, busy, done;
  logic [5:0] rd_addr, out_chunk;
  logic [4:0] out_pos;
  logic [31:0] rd_data;
  logic [10:0] set_count;
  logic [31:0] bank [63];
  logic [10:0] got_q [$];
  logic [10:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int dones;
  clause_out_scanner dut (
    .clk(clk),
    .rst_flag(rst_flag),
    .start(start),
    .rd_mode(rd_mode),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chunk(out_chunk),
    .out_pos(out_pos),
    .busy(busy),
    .done(done),
    .set_count(set_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= rd_mode ? bank[rd_addr] : 32'h0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  task automatic clear_bank();
    for (int i = 0; i < 63; i++) bank[i] = 32'h0;
  endtask
  task automatic scan(input string tag, input int exp_cyc, input int stall, input bit poke);
    int n;
    int s;
    bit fin;
    n = 1;
    s = stall;
    fin = 1'b0;
    got_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!fin && n <= 400) begin
      if (n == 1) begin
        check({tag, ".req"}, {25'h0, rd_mode, rd_addr}, 32'h40);
        check({tag, ".cnt0"}, {21'h0, set_count}, 32'h0);
      end
      if (poke) start = (n == 50);
      if (done) begin
        fin = 1'b1;
        check({tag, ".cycles"}, n, exp_cyc);
        if (poke) start = 1'b1;
      end else if (out_valid) begin
        if (s > 0) begin
          out_ready = 1'b0;
          s--;
          check({tag, ".hold"}, {21'h0, out_chunk, out_pos}, {21'h0, exp_q[0]});
        end else out_ready = 1'b1;
        if (out_ready) got_q.push_back({out_chunk, out_pos});
      end
      if (!fin) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!fin) check({tag, ".timeout"}, 0, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, ".idle"}, {31'h0, busy}, 32'h0);
    check({tag, ".n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, ".idx"}, {21'h0, got_q[i]}, {21'h0, exp_q[i]});
    check({tag, ".count"}, {21'h0, set_count}, exp_q.size());
  endtask
  initial begin
    rst_flag = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    clear_bank();
    repeat (3) @(posedge clk);
    #1;
    rst_flag = 1'b0;
    check("rst.rd", {25'h0, rd_mode, rd_addr}, 32'h0);
    check("rst.out", {20'h0, out_valid, out_chunk, out_pos}, 32'h0);
    check("rst.flags", {30'h0, busy, done}, 32'h0);
    check("rst.count", {21'h0, set_count}, 32'h0);
    exp_q.delete();
    scan("empty", 190, 0, 1'b0);
    bank[0] = 32'h8000_0001;
    exp_q = '{{6'd0, 5'd0}, {6'd0, 5'd31}};
    scan("ends", 192, 0, 1'b0);
    clear_bank();
    bank[62] = 32'hFFFF_FFFF;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back({6'd62, 5'(i)});
    scan("full", 222, 0, 1'b0);
    clear_bank();
    bank[5] = 32'h0000_0110;
    exp_q = '{{6'd5, 5'd4}, {6'd5, 5'd8}};
    scan("stall", 196, 4, 1'b0);
    clear_bank();
    bank[10] = 32'h0000_0001;
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort.chunk", {25'h0, out_valid, out_chunk}, 32'h4A);
    rst_flag = 1'b1;
    @(posedge clk);
    #1;
    rst_flag = 1'b0;
    check("abort.state", {29'h0, busy, out_valid, done}, 32'h0);
    check("abort.count", {21'h0, set_count}, 32'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      dones += int'(done) + int'(busy);
      @(posedge clk);
      #1;
    end
    check("abort.quiet", dones, 0);
    out_ready = 1'b1;
    exp_q = '{{6'd10, 5'd0}};
    scan("rescan", 191, 0, 1'b0);
    clear_bank();
    bank[0] = 32'h8000_0001;
    exp_q = '{{6'd0, 5'd0}, {6'd0, 5'd31}};
    scan("poke", 192, 0, 1'b1);
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      dones += int'(done) + int'(busy);
      @(posedge clk);
      #1;
    end
    check("poke.quiet", dones, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
